incr_check_seq: RTL and testbench

//  Sequencer/checker for the word-increment datapath (dout = din + 1). Pulls stimulus

---
 rtl/incr_check_seq.sv | 194 +++++++++++++++++++
 tb/tb_incr_check_seq.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/incr_check_seq.sv
// Stream sequencer/checker for a word-increment datapath with pass/fail stats.
// Optional FIRST_FAIL_CAPTURE_EN adds first-failing-entry capture outputs.
module incr_check_seq #(
    parameter int W       = 16,
    parameter int CW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    input  logic          in_last,
    output logic          in_ready,
    input  logic          exp_valid,
    input  logic [W-1:0]  exp_data,
    output logic          exp_ready,
    output logic          dp_req,
    output logic [W-1:0]  dp_din,
    input  logic          dp_ack,
    input  logic [W-1:0]  dp_dout,
    output logic          busy,
    output logic          done,
    output logic          test_fail,
    output logic          timeout,
    output logic [CW-1:0] pass_cnt,
    output logic [CW-1:0] fail_cnt
`ifdef FIRST_FAIL_CAPTURE_EN
    ,
    output logic [CW-1:0] ff_idx,
    output logic [W-1:0]  ff_exp,
    output logic [W-1:0]  ff_got,
    output logic          ff_vld
`endif
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT,
        EXPECT,
        DONE
    } state_t;

    state_t        state;
    state_t        state_n;
    logic          last_r;
    logic [TW-1:0] timer;
    logic [W-1:0]  result_r;
    logic          to_r;

    logic start_ok;
    logic in_hs;
    logic exp_hs;
    logic ack_hs;
    logic tmo_hit;
    logic match;

    assign busy     = (state != IDLE) && (state != DONE);
    assign start_ok = start && !busy;
    assign in_hs    = in_valid && in_ready;
    assign exp_hs   = exp_valid && exp_ready;
    assign ack_hs   = (state == WAIT) && dp_ack;
    assign tmo_hit  = (state == WAIT) && !dp_ack
                      && (timer == TW'(TIMEOUT - 1));
    assign match    = !to_r && (result_r == exp_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        exp_ready = 1'b0;
        dp_req    = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) state_n = FETCH;
            end
            FETCH: begin
                in_ready = 1'b1;
                if (in_valid) state_n = ISSUE;
            end
            ISSUE: begin
                dp_req  = 1'b1;
                state_n = WAIT;
            end
            WAIT: begin
                if (dp_ack || tmo_hit) state_n = EXPECT;
            end
            EXPECT: begin
                exp_ready = 1'b1;
                if (exp_valid) state_n = last_r ? DONE : FETCH;
            end
            default: state_n = IDLE;
        endcase
    end

    // Operand and result capture; a timed-out entry reads back as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_din   <= '0;
            last_r   <= 1'b0;
            timer    <= '0;
            result_r <= '0;
            to_r     <= 1'b0;
        end else begin
            if (in_hs) begin
                dp_din <= in_data;
                last_r <= in_last;
            end
            if (state == ISSUE) begin
                timer <= '0;
            end else if ((state == WAIT) && !dp_ack && !tmo_hit) begin
                timer <= timer + 1'b1;
            end
            if (ack_hs) begin
                result_r <= dp_dout;
                to_r     <= 1'b0;
            end else if (tmo_hit) begin
                result_r <= '0;
                to_r     <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            test_fail <= 1'b0;
            timeout   <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (start_ok) begin
                pass_cnt  <= '0;
                fail_cnt  <= '0;
                test_fail <= 1'b0;
                timeout   <= 1'b0;
                done      <= 1'b0;
            end
            if (tmo_hit) timeout <= 1'b1;
            if (exp_hs) begin
                if (match) begin
                    if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
                end else begin
                    if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
                    test_fail <= 1'b1;
                end
                if (last_r) done <= 1'b1;
            end
        end
    end

`ifdef FIRST_FAIL_CAPTURE_EN
    logic [CW-1:0] idx_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r  <= '0;
            ff_idx <= '0;
            ff_exp <= '0;
            ff_got <= '0;
            ff_vld <= 1'b0;
        end else begin
            if (start_ok) begin
                idx_r  <= '0;
                ff_idx <= '0;
                ff_exp <= '0;
                ff_got <= '0;
                ff_vld <= 1'b0;
            end
            if (exp_hs) begin
                idx_r <= idx_r + 1'b1;
                if (!match && !ff_vld) begin
                    ff_idx <= idx_r;
                    ff_exp <= exp_data;
                    ff_got <= result_r;
                    ff_vld <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_incr_check_seq.sv
// Directed bench for incr_check_seq with a +1 datapath model.
// Second instance uses CW=2 to exercise counter saturation.
module tb_incr_check_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        exp_valid = 1'b0;
    logic [15:0] exp_data = '0;
    logic        exp_ready;
    logic        dp_req;
    logic [15:0] dp_din;
    logic        dp_ack;
    logic [15:0] dp_dout;
    logic        busy, done, test_fail, timeout;
    logic [15:0] pass_cnt, fail_cnt;

    logic        s_in_ready, s_exp_ready, s_dp_req;
    logic [15:0] s_dp_din;
    logic        s_busy, s_done, s_test_fail, s_timeout;
    logic [1:0]  s_pass_cnt, s_fail_cnt;

`ifdef FIRST_FAIL_CAPTURE_EN
    logic [15:0] ff_idx, ff_exp, ff_got;
    logic        ff_vld;
    logic [1:0]  s_ff_idx;
    logic [15:0] s_ff_exp, s_ff_got;
    logic        s_ff_vld;
`endif

    logic        drop_en = 1'b0;
    logic        both_hi = 1'b0;
    int          errors = 0;
    int          checks = 0;
    logic [15:0] stim_q[$];
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    incr_check_seq #(.W(16), .CW(16), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready),
        .exp_valid(exp_valid), .exp_data(exp_data),
        .exp_ready(exp_ready),
        .dp_req(dp_req), .dp_din(dp_din),
        .dp_ack(dp_ack), .dp_dout(dp_dout),
        .busy(busy), .done(done), .test_fail(test_fail),
        .timeout(timeout), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
`ifdef FIRST_FAIL_CAPTURE_EN
        , .ff_idx(ff_idx), .ff_exp(ff_exp),
        .ff_got(ff_got), .ff_vld(ff_vld)
`endif
    );

    incr_check_seq #(.W(16), .CW(2), .TIMEOUT(16)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(s_in_ready),
        .exp_valid(exp_valid), .exp_data(exp_data),
        .exp_ready(s_exp_ready),
        .dp_req(s_dp_req), .dp_din(s_dp_din),
        .dp_ack(dp_ack), .dp_dout(dp_dout),
        .busy(s_busy), .done(s_done), .test_fail(s_test_fail),
        .timeout(s_timeout), .pass_cnt(s_pass_cnt),
        .fail_cnt(s_fail_cnt)
`ifdef FIRST_FAIL_CAPTURE_EN
        , .ff_idx(s_ff_idx), .ff_exp(s_ff_exp),
        .ff_got(s_ff_got), .ff_vld(s_ff_vld)
`endif
    );

    // Datapath: result one cycle after request; one operand can be made to hang.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_ack  <= 1'b0;
            dp_dout <= '0;
        end else begin
            dp_ack <= 1'b0;
            if (dp_req && !(drop_en && dp_din == 16'h0BAD)) begin
                dp_ack  <= 1'b1;
                dp_dout <= dp_din + 16'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (in_ready && exp_ready) both_hi = 1'b1;
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_stim(input int gap);
        int k;
        for (int i = 0; i < stim_q.size(); i++) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
            in_valid = 1'b1;
            in_data  = stim_q[i];
            in_last  = (i == stim_q.size() - 1);
            k = 0;
            while (!in_ready && k < 200) begin
                @(negedge clk);
                k++;
            end
            if (!in_ready) begin
                errors++;
                checks++;
                $display("FAIL stim_hs: in_ready=0 after %0d cycles, need 1", k);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_exp(input int gap);
        int k;
        for (int i = 0; i < exp_q.size(); i++) begin
            exp_valid = 1'b0;
            repeat (gap) @(negedge clk);
            exp_valid = 1'b1;
            exp_data  = exp_q[i];
            k = 0;
            while (!exp_ready && k < 200) begin
                @(negedge clk);
                k++;
            end
            if (!exp_ready) begin
                errors++;
                checks++;
                $display("FAIL exp_hs: exp_ready=0 after %0d cycles, need 1", k);
                exp_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        exp_valid = 1'b0;
    endtask

    task automatic run_seq(input int gap);
        int k;
        pulse_start();
        fork
            send_stim(gap);
            send_exp(gap);
        join
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic chk_run(input string nm, input logic [15:0] p,
                           input logic [15:0] f, input logic tf,
                           input logic to);
        checks++;
        if (pass_cnt !== p || fail_cnt !== f || test_fail !== tf
            || timeout !== to || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: pass=%0d fail=%0d tf=%b to=%b done=%b busy=%b, need pass=%0d fail=%0d tf=%b to=%b done=1 busy=0",
                     nm, pass_cnt, fail_cnt, test_fail, timeout, done, busy,
                     p, f, tf, to);
        end
    endtask

    task automatic load_basic();
        stim_q = '{16'h0102, 16'h00FF, 16'hFFFF};
        exp_q  = '{16'h0103, 16'h0100, 16'h0000};
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({in_ready, exp_ready, dp_req, busy, done, test_fail,
             timeout} !== 7'b0 || dp_din !== 16'h0
            || pass_cnt !== 16'h0 || fail_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset: rdy=%b%b req=%b busy=%b done=%b din=%h p=%0d f=%0d, need all 0",
                     in_ready, exp_ready, dp_req, busy, done, dp_din,
                     pass_cnt, fail_cnt);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        load_basic();
        run_seq(0);
        chk_run("basic", 16'd3, 16'd0, 1'b0, 1'b0);
    endtask

    task automatic test_mismatch();
        load_basic();
        exp_q[1] = 16'h0101;
        run_seq(0);
        chk_run("mismatch", 16'd2, 16'd1, 1'b1, 1'b0);
`ifdef FIRST_FAIL_CAPTURE_EN
        checks++;
        if (ff_idx !== 16'd1 || ff_exp !== 16'h0101
            || ff_got !== 16'h0100 || ff_vld !== 1'b1) begin
            errors++;
            $display("FAIL first_fail: idx=%0d exp=%h got=%h vld=%b, need 1 0101 0100 1",
                     ff_idx, ff_exp, ff_got, ff_vld);
        end
`endif
    endtask

    task automatic test_timeout();
        int k;
        int w;
        stim_q  = '{16'h0BAD, 16'h0010};
        exp_q   = '{16'h0BAE, 16'h0011};
        drop_en = 1'b1;
        w = 0;
        fork
            run_seq(0);
            begin
                k = 0;
                while (!dp_req && k < 50) begin
                    @(negedge clk);
                    k++;
                end
                while (!exp_ready && w < 40) begin
                    @(negedge clk);
                    w++;
                end
            end
        join
        drop_en = 1'b0;
        checks++;
        if (w !== 17) begin
            errors++;
            $display("FAIL timeout_len: req-to-expect=%0d cycles, need 17", w);
        end
        chk_run("timeout", 16'd1, 16'd1, 1'b1, 1'b1);
    endtask

    task automatic test_stall();
        load_basic();
        both_hi = 1'b0;
        run_seq(5);
        chk_run("stall", 16'd3, 16'd0, 1'b0, 1'b0);
        checks++;
        if (both_hi !== 1'b0) begin
            errors++;
            $display("FAIL ready_excl: both readies seen high=%b, need 0", both_hi);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        stim_q  = '{16'h0001, 16'h0BAD};
        exp_q   = '{16'h0002};
        drop_en = 1'b1;
        pulse_start();
        fork
            send_stim(0);
            send_exp(0);
        join
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || dp_din !== 16'h0BAD || pass_cnt !== 16'd1) begin
            errors++;
            $display("FAIL pre_reset: busy=%b din=%h pass=%0d, need 1 0bad 1",
                     busy, dp_din, pass_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, exp_ready, dp_req, busy, done, test_fail,
             timeout} !== 7'b0 || dp_din !== 16'h0
            || pass_cnt !== 16'h0 || fail_cnt !== 16'h0) begin
            errors++;
            $display("FAIL async_reset: busy=%b din=%h p=%0d f=%0d, need all 0",
                     busy, dp_din, pass_cnt, fail_cnt);
        end
        drop_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_basic();
        fork
            run_seq(0);
            begin
                k = 0;
                while (pass_cnt != 16'd1 && k < 100) begin
                    @(negedge clk);
                    k++;
                end
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        chk_run("busy_start", 16'd3, 16'd0, 1'b0, 1'b0);
    endtask

    task automatic test_saturate();
        stim_q = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
        exp_q  = '{16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006};
        run_seq(0);
        chk_run("wide_cnt", 16'd5, 16'd0, 1'b0, 1'b0);
        checks++;
        if (s_pass_cnt !== 2'd3 || s_fail_cnt !== 2'd0 || s_done !== 1'b1) begin
            errors++;
            $display("FAIL saturate: pass=%0d fail=%0d done=%b, need 3 0 1",
                     s_pass_cnt, s_fail_cnt, s_done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mismatch();
        test_timeout();
        test_stall();
        test_reset_mid();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
